// File: rtl/excep_ctrl.sv
// Commit-side trap controller: turns ROB commit events and pending interrupts
// into flush pulses, fetch redirects, mepc/mcause writes and the minstret count.
module excep_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int PC_WIDTH     = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rob_commit_valid,
  input  logic                rob_cm_exp,
  input  logic [3:0]          rob_cm_ecause,
  input  logic                rob_cm_mret,
  input  logic                rob_cm_wfi,
  input  logic [PC_WIDTH-1:0] rob_cm_exp_pc,
  input  logic [PC_WIDTH-1:0] rob_cm_next_pc,
  input  logic                irq_pending,
  input  logic [3:0]          irq_cause,
  input  logic [PC_WIDTH-1:0] mtvec,
  input  logic [PC_WIDTH-1:0] mepc_in,
  output logic                trapped,
  output logic                wfi_ctrl,
  output logic                redirect_valid,
  output logic [PC_WIDTH-1:0] redirect_pc,
  output logic                csr_trap_we,
  output logic [PC_WIDTH-1:0] csr_mepc,
  output logic [31:0]         csr_mcause,
  output logic                csr_mret,
  output logic [63:0]         minstret
);

  typedef enum logic [1:0] {IDLE, FLUSH, WFI} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [PC_WIDTH-1:0] target_q, target_d;
  logic [PC_WIDTH-1:0] wfi_pc_q, wfi_pc_d;
  logic                trapped_q, trapped_d;
  logic                wfi_ctrl_q, wfi_ctrl_d;
  logic                redirect_valid_q, redirect_valid_d;
  logic [PC_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic                csr_trap_we_q, csr_trap_we_d;
  logic [PC_WIDTH-1:0] csr_mepc_q, csr_mepc_d;
  logic [31:0]         csr_mcause_q, csr_mcause_d;
  logic                csr_mret_q, csr_mret_d;
  logic [63:0]         minstret_q, minstret_d;

  logic [PC_WIDTH-1:0] base_pc;
  logic [PC_WIDTH-1:0] irq_target;
  logic                take_flush;
  logic                take_irq;
  logic [PC_WIDTH-1:0] irq_mepc;

  assign base_pc    = mtvec & ~PC_WIDTH'(3);
  // Vectored mode offsets interrupts by 4*cause; exceptions never use this.
  assign irq_target = mtvec[0] ? base_pc + (PC_WIDTH'(irq_cause) << 2) : base_pc;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    target_d         = target_q;
    wfi_pc_d         = wfi_pc_q;
    trapped_d        = 1'b0;
    wfi_ctrl_d       = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    csr_trap_we_d    = 1'b0;
    csr_mepc_d       = csr_mepc_q;
    csr_mcause_d     = csr_mcause_q;
    csr_mret_d       = 1'b0;
    minstret_d       = minstret_q + 64'(rob_commit_valid & ~rob_cm_exp);
    take_flush       = 1'b0;
    take_irq         = 1'b0;
    irq_mepc         = rob_cm_next_pc;

    case (state_q)
      IDLE: begin
        if (rob_commit_valid) begin
          if (rob_cm_exp) begin
            take_flush    = 1'b1;
            csr_trap_we_d = 1'b1;
            csr_mepc_d    = rob_cm_exp_pc;
            csr_mcause_d  = {28'b0, rob_cm_ecause};
            target_d      = base_pc;
          end else if (rob_cm_mret) begin
            take_flush = 1'b1;
            csr_mret_d = 1'b1;
            target_d   = mepc_in;
          end else if (rob_cm_wfi && !irq_pending) begin
            state_d    = WFI;
            wfi_pc_d   = rob_cm_next_pc;
            wfi_ctrl_d = 1'b1;
          end else if (irq_pending) begin
            take_irq = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d            = cnt_q - 4'd1;
          trapped_d        = 1'b1;
          wfi_ctrl_d       = 1'b1;
          redirect_valid_d = (cnt_q == 4'd1);
        end
      end
      WFI: begin
        wfi_ctrl_d = 1'b1;
        irq_mepc   = wfi_pc_q;
        take_irq   = irq_pending;
      end
      default: state_d = IDLE;
    endcase

    if (take_irq) begin
      take_flush    = 1'b1;
      csr_trap_we_d = 1'b1;
      csr_mepc_d    = irq_mepc;
      csr_mcause_d  = {1'b1, 27'b0, irq_cause};
      target_d      = irq_target;
    end

    // cnt holds the FLUSH cycles still to come after the current one.
    if (take_flush) begin
      state_d          = FLUSH;
      cnt_d            = 4'(FLUSH_CYCLES - 1);
      trapped_d        = 1'b1;
      wfi_ctrl_d       = 1'b1;
      redirect_valid_d = (FLUSH_CYCLES == 1);
    end

    if (redirect_valid_d) redirect_pc_d = target_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      target_q         <= '0;
      wfi_pc_q         <= '0;
      trapped_q        <= 1'b0;
      wfi_ctrl_q       <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      csr_trap_we_q    <= 1'b0;
      csr_mepc_q       <= '0;
      csr_mcause_q     <= '0;
      csr_mret_q       <= 1'b0;
      minstret_q       <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      target_q         <= target_d;
      wfi_pc_q         <= wfi_pc_d;
      trapped_q        <= trapped_d;
      wfi_ctrl_q       <= wfi_ctrl_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      csr_trap_we_q    <= csr_trap_we_d;
      csr_mepc_q       <= csr_mepc_d;
      csr_mcause_q     <= csr_mcause_d;
      csr_mret_q       <= csr_mret_d;
      minstret_q       <= minstret_d;
    end
  end

  assign trapped        = trapped_q;
  assign wfi_ctrl       = wfi_ctrl_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign csr_trap_we    = csr_trap_we_q;
  assign csr_mepc       = csr_mepc_q;
  assign csr_mcause     = csr_mcause_q;
  assign csr_mret       = csr_mret_q;
  assign minstret       = minstret_q;

endmodule

// File: tb/tb_excep_ctrl.sv
// Directed bench for excep_ctrl: trap/redirect records go through expected
// queues checked by a negedge monitor; timing and counters are checked inline.
module tb_excep_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        rob_commit_valid, rob_cm_exp, rob_cm_mret, rob_cm_wfi;
  logic [3:0]  rob_cm_ecause, irq_cause;
  logic [31:0] rob_cm_exp_pc, rob_cm_next_pc, mtvec, mepc_in;
  logic        irq_pending;
  logic        trapped, wfi_ctrl, redirect_valid, csr_trap_we, csr_mret;
  logic [31:0] redirect_pc, csr_mepc, csr_mcause;
  logic [63:0] minstret;

  int tests = 0;
  int fails = 0;

  // Trap record: {trap_we, mret, mepc, mcause}
  logic [65:0] exp_q[$];
  logic [31:0] redir_q[$];

  excep_ctrl #(.FLUSH_CYCLES(2), .PC_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .rob_commit_valid(rob_commit_valid), .rob_cm_exp(rob_cm_exp),
    .rob_cm_ecause(rob_cm_ecause), .rob_cm_mret(rob_cm_mret),
    .rob_cm_wfi(rob_cm_wfi), .rob_cm_exp_pc(rob_cm_exp_pc),
    .rob_cm_next_pc(rob_cm_next_pc), .irq_pending(irq_pending),
    .irq_cause(irq_cause), .mtvec(mtvec), .mepc_in(mepc_in),
    .trapped(trapped), .wfi_ctrl(wfi_ctrl), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .csr_trap_we(csr_trap_we), .csr_mepc(csr_mepc),
    .csr_mcause(csr_mcause), .csr_mret(csr_mret), .minstret(minstret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_commit();
    rob_commit_valid = 1'b0;
    rob_cm_exp       = 1'b0;
    rob_cm_mret      = 1'b0;
    rob_cm_wfi       = 1'b0;
    rob_cm_ecause    = 4'd0;
  endtask

  task automatic commit(input logic exp, input logic [3:0] ecause, input logic mret,
                        input logic wfi, input logic [31:0] pc, input logic [31:0] npc);
    rob_commit_valid = 1'b1;
    rob_cm_exp       = exp;
    rob_cm_ecause    = ecause;
    rob_cm_mret      = mret;
    rob_cm_wfi       = wfi;
    rob_cm_exp_pc    = pc;
    rob_cm_next_pc   = npc;
    tick();
    clear_commit();
  endtask

  // Monitor: pop expected records when the DUT emits strobes.
  always @(negedge clk) begin
    if (!reset) begin
      if (csr_trap_we || csr_mret) begin
        if (exp_q.size() == 0) begin
          chk("trap_unexpected", {csr_trap_we, csr_mret}, 66'd0);
        end else begin
          logic [65:0] e;
          e = exp_q.pop_front();
          if (e[64]) chk("mret_strobes", {64'd0, csr_trap_we, csr_mret}, {64'd0, e[65:64]});
          else       chk("trap_record", {csr_trap_we, csr_mret, csr_mepc, csr_mcause}, e);
        end
      end
      if (redirect_valid) begin
        if (redir_q.size() == 0) chk("redirect_unexpected", 66'(redirect_valid), 66'd0);
        else chk("redirect_pc", 66'(redirect_pc), 66'(redir_q.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b1;
    clear_commit();
    rob_cm_exp_pc = '0; rob_cm_next_pc = '0;
    irq_pending = 1'b0; irq_cause = 4'd0;
    mtvec = 32'h8000_0000; mepc_in = '0;
    tick(); tick();
    reset = 1'b0;
    chk("reset_outs", {60'd0, trapped, wfi_ctrl, redirect_valid, csr_trap_we, csr_mret, 1'b0}, 66'd0);
    chk("reset_minstret", 66'(minstret), 66'd0);

    // Exception flush
    exp_q.push_back({1'b1, 1'b0, 32'h100, 32'h2});
    redir_q.push_back(32'h8000_0000);
    commit(1'b1, 4'd2, 1'b0, 1'b0, 32'h100, 32'h104);
    chk("exc_f1", {63'd0, trapped, wfi_ctrl, redirect_valid}, {63'd0, 3'b110});
    chk("exc_minstret", 66'(minstret), 66'd0);
    tick();
    chk("exc_f2", {63'd0, trapped, wfi_ctrl, redirect_valid}, {63'd0, 3'b111});
    tick();
    chk("exc_done", {63'd0, trapped, wfi_ctrl, redirect_valid}, 66'd0);
    chk("redirect_hold", 66'(redirect_pc), 66'h8000_0000);

    // Vectored interrupt on a normal commit
    mtvec = 32'h8000_0001; irq_pending = 1'b1; irq_cause = 4'd7;
    exp_q.push_back({1'b1, 1'b0, 32'h204, 32'h8000_0007});
    redir_q.push_back(32'h8000_001C);
    commit(1'b0, 4'd0, 1'b0, 1'b0, 32'h200, 32'h204);
    irq_pending = 1'b0;
    chk("irq_trapped", 66'(trapped), 66'd1);
    chk("irq_minstret", 66'(minstret), 66'd1);
    tick(); tick();

    // Pending interrupt with no commit: stay idle
    irq_pending = 1'b1; irq_cause = 4'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("irq_no_commit", {64'd0, trapped, wfi_ctrl}, 66'd0);
    end
    irq_pending = 1'b0;
    mtvec = 32'h8000_0000;

    // WFI wait then wake on interrupt
    commit(1'b0, 4'd0, 1'b0, 1'b1, 32'h2FC, 32'h300);
    chk("wfi_minstret", 66'(minstret), 66'd2);
    for (int i = 0; i < 10; i++) begin
      chk("wfi_hold", {64'd0, wfi_ctrl, trapped}, {64'd0, 2'b10});
      tick();
    end
    irq_pending = 1'b1; irq_cause = 4'd3;
    exp_q.push_back({1'b1, 1'b0, 32'h300, 32'h8000_0003});
    redir_q.push_back(32'h8000_0000);
    tick();
    irq_pending = 1'b0;
    chk("wfi_wake", {64'd0, trapped, wfi_ctrl}, {64'd0, 2'b11});
    tick(); tick();

    // WFI with interrupt already pending acts as nop then interrupt
    irq_pending = 1'b1; irq_cause = 4'd5;
    exp_q.push_back({1'b1, 1'b0, 32'h310, 32'h8000_0005});
    redir_q.push_back(32'h8000_0000);
    commit(1'b0, 4'd0, 1'b0, 1'b1, 32'h30C, 32'h310);
    irq_pending = 1'b0;
    chk("wfi_irq_minstret", 66'(minstret), 66'd3);
    tick(); tick();

    // Exception beats mret
    exp_q.push_back({1'b1, 1'b0, 32'h120, 32'h4});
    redir_q.push_back(32'h8000_0000);
    commit(1'b1, 4'd4, 1'b1, 1'b0, 32'h120, 32'h124);
    chk("prio_no_mret", 66'(csr_mret), 66'd0);
    tick(); tick();

    // mret
    mepc_in = 32'h444;
    exp_q.push_back({1'b0, 1'b1, 64'd0});
    redir_q.push_back(32'h444);
    commit(1'b0, 4'd0, 1'b1, 1'b0, 32'h400, 32'h404);
    chk("mret_minstret", 66'(minstret), 66'd4);
    tick(); tick();

    // Reset in FLUSH cycle 1
    exp_q.push_back({1'b1, 1'b0, 32'h500, 32'h6});
    commit(1'b1, 4'd6, 1'b0, 1'b0, 32'h500, 32'h504);
    @(negedge clk); #1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_outs", {62'd0, trapped, wfi_ctrl, redirect_valid, csr_trap_we}, 66'd0);
    chk("rst_mid_minstret", 66'(minstret), 66'd0);
    exp_q.push_back({1'b1, 1'b0, 32'h600, 32'h1});
    redir_q.push_back(32'h8000_0000);
    commit(1'b1, 4'd1, 1'b0, 1'b0, 32'h600, 32'h604);
    chk("post_rst_trap", 66'(trapped), 66'd1);
    tick(); tick();

    // minstret wrap
    force dut.minstret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.minstret_q;
    commit(1'b0, 4'd0, 1'b0, 1'b0, 32'h700, 32'h704);
    chk("minstret_wrap", 66'(minstret), 66'd0);
    tick();

    chk("trap_q_empty", 66'(exp_q.size()), 66'd0);
    chk("redir_q_empty", 66'(redir_q.size()), 66'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/excep_ctrl.md
Name: excep_ctrl

Overview:
- Commit-side trap controller directly downstream of the rename/ROB unit.
- Consumes the ROB commit stream: commit valid, exception flag/cause, mret, wfi and PC.
- Decides when to take exceptions, interrupts, mret and wfi, and drives back into the ROB the `trapped` flush pulse and the `wfi_ctrl` stall level.
- Produces the fetch redirect and the mepc/mcause CSR updates, and keeps the retired-instruction count.

Parameters:
- FLUSH_CYCLES, 2, number of cycles `trapped` stays asserted per flush (1..15).
- PC_WIDTH, 32, PC width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- rob_commit_valid  in  1  ROB head commits this cycle
- rob_cm_exp  in  1  committing entry carries an exception
- rob_cm_ecause  in  4  exception cause of the committing entry
- rob_cm_mret  in  1  committing entry is mret
- rob_cm_wfi  in  1  committing entry is wfi
- rob_cm_exp_pc  in  PC_WIDTH  PC of the committing entry
- rob_cm_next_pc  in  PC_WIDTH  next PC of the committing entry
- irq_pending  in  1  enabled, masked interrupt pending (from CSR unit)
- irq_cause  in  4  interrupt cause code
- mtvec  in  PC_WIDTH  trap vector; bit0 = vectored mode
- mepc_in  in  PC_WIDTH  current mepc, used for mret
- trapped  out  1  flush pulse to ROB/rename
- wfi_ctrl  out  1  blocks ROB issue/commit
- redirect_valid  out  1  one-cycle fetch redirect
- redirect_pc  out  PC_WIDTH  redirect target
- csr_trap_we  out  1  one-cycle write strobe for mepc/mcause
- csr_mepc  out  PC_WIDTH  mepc value to write
- csr_mcause  out  32  {interrupt, 27'b0, cause[3:0]}
- csr_mret  out  1  one-cycle strobe, restores mstatus
- minstret  out  64  retired-instruction count

Behaviour:
- Reset: all outputs 0; state IDLE; flush counter 0; minstret 0. Reset asserted in any state returns to IDLE on the next edge and drops every pulse.
- States: IDLE, FLUSH, WFI.
- minstret increments on every cycle with `rob_commit_valid & !rob_cm_exp`, including mret and wfi commits. It wraps at 2^64.
- In IDLE, events are evaluated only when `rob_commit_valid` is high, in strict priority order:
  - rob_cm_exp: mepc = rob_cm_exp_pc; mcause = {0, ecause}; target = {mtvec[31:2], 2'b00}; go to FLUSH.
  - rob_cm_mret: target = mepc_in; csr_mret pulses; go to FLUSH; no CSR trap write.
  - rob_cm_wfi with irq_pending low: latch rob_cm_next_pc; go to WFI.
  - rob_cm_wfi with irq_pending high: wfi acts as a nop; fall through to the irq rule below.
  - irq_pending (any other commit): mepc = rob_cm_next_pc; mcause = {1, irq_cause}; go to FLUSH.
  - Nothing matched: stay in IDLE.
- Interrupts are taken only on a non-exception commit boundary. While irq_pending is high and nothing commits, the block stays in IDLE.
- Trap target for an interrupt with mtvec[0]=1: {mtvec[31:2], 2'b00} + (irq_cause << 2), modulo 2^PC_WIDTH. Exceptions always use the base address.
- csr_trap_we, csr_mepc and csr_mcause are registered: the strobe is high for exactly one cycle, the first cycle of FLUSH.
- FLUSH:
  - trapped = 1 and wfi_ctrl = 1 for exactly FLUSH_CYCLES cycles.
  - Commit inputs are ignored.
  - In the last FLUSH cycle, redirect_valid = 1 and redirect_pc = target.
  - Next state is IDLE.
- WFI:
  - wfi_ctrl = 1; trapped = 0.
  - When irq_pending is seen: mepc = latched next PC; mcause = {1, irq_cause}; go to FLUSH.
  - Commit inputs are ignored.
- Back-to-back: an event may be taken on the first IDLE cycle after FLUSH.
- redirect_pc holds its last value when redirect_valid is low.

Test Plan:
- Exception flush: commit exp=1, ecause=2, pc=0x100, mtvec=0x8000_0000, FLUSH_CYCLES=2.
  - Next cycle: csr_trap_we=1, csr_mepc=0x100, csr_mcause=0x2.
  - trapped high for 2 cycles; redirect_valid with redirect_pc=0x8000_0000 on the 2nd cycle.
  - minstret unchanged.
- Vectored interrupt: irq_pending=1, irq_cause=7, mtvec=0x8000_0001, commit of a normal instruction with next_pc=0x204.
  - mcause=0x8000_0007, mepc=0x204, redirect_pc=0x8000_001C.
  - minstret +1.
- WFI wait: commit wfi (next_pc=0x300) with irq low.
  - wfi_ctrl=1 and stays high for 10 idle cycles, trapped=0.
  - Raise irq_pending (cause 3): FLUSH with mepc=0x300, mcause=0x8000_0003.
- Priority and mret:
  - Commit with exp=1 and mret=1 together: exception is taken, csr_mret=0.
  - A later mret commit with mepc_in=0x444: csr_mret=1, csr_trap_we=0, redirect_pc=0x444.
- Reset mid-flush: assert reset in FLUSH cycle 1.
  - trapped, wfi_ctrl and redirect_valid are all 0 the following cycle; minstret=0; the next exception commit is handled normally.
- Counter wrap: preload by committing until minstret=2^64-1 (or force), then one more commit → minstret reads 0.
